// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-word fills from memory control.
// Define ICACHE_STATS_EN to add the hit_count/miss_count counters.
module icache #(
    parameter int NSETS = 16,
    parameter int IDX_W = $clog2(NSETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    typedef enum logic {IDLE, FILL} state_e;

    state_e           state_q;
    logic [31:0]      miss_addr_q;
    logic [NSETS-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [NSETS];
    logic [31:0]      data_q [NSETS];

    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] req_tag;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             fill_done;
    logic             unused_offset;

    assign req_idx       = imemaddr[IDX_W+1:2];
    assign req_tag       = imemaddr[31:IDX_W+2];
    assign fill_idx      = miss_addr_q[IDX_W+1:2];
    assign fill_tag      = miss_addr_q[31:IDX_W+2];
    assign unused_offset = ^imemaddr[1:0];

    assign hit       = (state_q == IDLE) && imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign ihit      = hit;
    assign imemload  = hit ? data_q[req_idx] : 32'h0;
    assign iREN      = (state_q == FILL);
    assign iaddr     = iREN ? miss_addr_q : 32'h0;
    assign fill_done = iREN && !iwait;

    // The fill always lands on miss_addr_q, regardless of what the fetch stage does meanwhile.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= 32'h0;
            valid_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (imemREN && !hit) begin
                        state_q     <= FILL;
                        miss_addr_q <= {imemaddr[31:2], 2'b00};
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        state_q           <= IDLE;
                        valid_q[fill_idx] <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/data need no reset: valid_q gates every read.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == IDLE) && imemREN && !hit) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Bench for icache: vector table, hand-written redirect/reset sequences, random fetches
// checked every cycle against a frame-level model of a direct-mapped cache.
module tb_icache;
    localparam int NS = 16;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache #(.NSETS(NS)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iload(iload), .iwait(iwait)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: which memory word each frame holds, plus the outstanding fill.
    bit          m_val  [NS];
    logic [29:0] m_word [NS];
    bit          m_busy;
    logic [31:0] m_addr;
    int unsigned m_hits;
    int unsigned m_misses;

    // Memory responder state.
    int lat = 0;
    int wait_left = 0;
    bit in_fill = 0;

    typedef struct {
        logic [31:0] addr;
        int          lat;
        logic        exp_hit;
        int          exp_fills;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h40) return 32'h2001_0005;
        return (w * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic int fidx(input logic [31:0] a);
        return int'((a >> 2) % NS);
    endfunction

    function automatic bit m_hit_now();
        return !m_busy && imemREN && m_val[fidx(imemaddr)] && (m_word[fidx(imemaddr)] == imemaddr[31:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_val[i] = 0;
        m_busy = 0;
        m_addr = 32'h0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit eh;
        eh = m_hit_now();
        chk("ihit", {31'd0, ihit}, {31'd0, eh});
        chk("imemload", imemload, eh ? mem_word(imemaddr) : 32'h0);
        chk("iREN", {31'd0, iREN}, {31'd0, m_busy});
        chk("iaddr", iaddr, m_busy ? m_addr : 32'h0);
`ifdef ICACHE_STATS_EN
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
`endif
    endtask

    task automatic mem_drive();
        if (iREN) begin
            if (!in_fill) begin
                in_fill = 1;
                wait_left = lat;
            end else if (wait_left > 0) begin
                wait_left--;
            end
        end else begin
            in_fill = 0;
        end
        iwait = iREN && (wait_left > 0);
        iload = (iREN && !iwait) ? mem_word(iaddr) : 32'hDEAD_BEEF;
    endtask

    // Advance one clock: step the model with the inputs the DUT sees at this edge.
    task automatic tick();
        if (nRST) begin
            if (!m_busy) begin
                if (m_hit_now()) begin
                    m_hits++;
                end else if (imemREN) begin
                    m_busy = 1;
                    m_addr = {imemaddr[31:2], 2'b00};
                    m_misses++;
                end
            end else if (!iwait) begin
                m_val[fidx(m_addr)] = 1;
                m_word[fidx(m_addr)] = m_addr[31:2];
                m_busy = 0;
            end
        end
        @(posedge CLK);
        #1;
        mem_drive();
    endtask

    task automatic fetch(input vec_t v, input string nm);
        int fills;
        int n;
        fills = 0;
        n = 0;
        lat = v.lat;
        imemREN = 1'b1;
        imemaddr = v.addr;
        #1;
        check_outputs();
        chk({nm, "_first_hit"}, {31'd0, ihit}, {31'd0, v.exp_hit});
        while (!ihit && n < 40) begin
            tick();
            #1;
            check_outputs();
            if (iREN) fills++;
            n++;
        end
        chk({nm, "_eventual_hit"}, {31'd0, ihit}, 32'd1);
        chk({nm, "_fill_cycles"}, fills, v.exp_fills);
        chk({nm, "_word"}, imemload, v.exp_word);
        tick();
        imemREN = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        int n;
        vecs[0] = '{32'h0000_0040, 3, 1'b0, 4, 32'h2001_0005};  // cold miss
        vecs[1] = '{32'h0000_0040, 0, 1'b1, 0, 32'h2001_0005};  // warm hit
        vecs[2] = '{32'h0000_0043, 0, 1'b1, 0, 32'h2001_0005};  // byte offset
        vecs[3] = '{32'h0000_0080, 1, 1'b0, 2, mem_word(32'h80)};
        vecs[4] = '{32'h0000_0040, 0, 1'b0, 1, 32'h2001_0005};  // evicted by 0x80
        vecs[5] = '{32'h0000_0044, 2, 1'b0, 3, mem_word(32'h44)};
        vecs[6] = '{32'h0000_0042, 0, 1'b1, 0, 32'h2001_0005};
        vecs[7] = '{32'h0000_0047, 0, 1'b1, 0, mem_word(32'h44)};

        nRST = 1'b0;
        imemREN = 1'b1;
        imemaddr = 32'h40;
        iwait = 1'b0;
        iload = 32'h0;
        model_reset();
        @(posedge CLK);
        #2;
        check_outputs();
        imemREN = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        #1;
        check_outputs();

        for (int i = 0; i < 8; i++) fetch(vecs[i], $sformatf("vec%0d", i));
`ifdef ICACHE_STATS_EN
        chk("miss_count_conflict", miss_count, 32'd4);
`endif

        // Redirect while the 0x100 fill is outstanding.
        lat = 3;
        imemREN = 1'b1;
        imemaddr = 32'h100;
        #1;
        check_outputs();
        chk("redir_miss", {31'd0, ihit}, 32'd0);
        tick();
        imemaddr = 32'h200;
        #1;
        check_outputs();
        chk("redir_iREN", {31'd0, iREN}, 32'd1);
        chk("redir_iaddr", iaddr, 32'h100);
        n = 0;
        while (iwait && n < 20) begin
            tick();
            #1;
            check_outputs();
            chk("redir_iaddr_hold", iaddr, 32'h100);
            n++;
        end
        chk("redir_fill_done", {31'd0, iwait}, 32'd0);
        tick();
        imemaddr = 32'h100;
        #1;
        check_outputs();
        chk("redir_frame_hit", {31'd0, ihit}, 32'd1);
        chk("redir_frame_word", imemload, mem_word(32'h100));
        tick();
        imemaddr = 32'h200;
        lat = 0;
        #1;
        check_outputs();
        chk("redir_new_miss", {31'd0, ihit}, 32'd0);
        tick();
        #1;
        check_outputs();
        chk("redir_new_iaddr", iaddr, 32'h200);
        tick();
        imemREN = 1'b0;
        #1;
        check_outputs();

        // Reset in the middle of a fill.
        fetch('{32'h0000_0040, 0, 1'b0, 1, 32'h2001_0005}, "pre_rst");
        lat = 5;
        imemREN = 1'b1;
        imemaddr = 32'h48;
        #1;
        tick();
        tick();
        #2;
        chk("rst_pre_iREN", {31'd0, iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("rst_iREN_async", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'h0);
        model_reset();
        in_fill = 0;
        iwait = 1'b0;
        imemREN = 1'b0;
        check_outputs();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        #1;
        check_outputs();
        fetch('{32'h0000_0040, 2, 1'b0, 3, 32'h2001_0005}, "post_rst");

        // Random fetch stream over 48 words: plenty of aliasing across 16 frames.
        for (int c = 0; c < 600; c++) begin
            if (!in_fill) lat = $urandom_range(0, 3);
            imemREN = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) != 0)
                imemaddr = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
            #1;
            check_outputs();
            tick();
        end
        imemREN = 1'b0;
        #1;
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
